// File: rtl/firmware_store_if.sv
// Fetch, image-load and CPU-hold signals between firmware_store and its neighbours.
interface firmware_store_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_valid;
  logic                  ld_start;
  logic                  ld_byte_valid;
  logic [7:0]            ld_byte;
  logic                  ld_end;
  logic                  cpu_hold;
  logic                  ld_done;
  logic [ADDR_WIDTH:0]   ld_count;
  logic                  ld_overflow;

  modport slave (
    input  fetch_valid, fetch_addr, ld_start, ld_byte_valid, ld_byte, ld_end,
    output fetch_ready, rdata, rdata_valid, cpu_hold, ld_done, ld_count, ld_overflow
  );

  modport master (
    output fetch_valid, fetch_addr, ld_start, ld_byte_valid, ld_byte, ld_end,
    input  fetch_ready, rdata, rdata_valid, cpu_hold, ld_done, ld_count, ld_overflow
  );
endinterface

// File: rtl/firmware_store.sv
// Loadable instruction memory: fills with FILL_WORD after reset, serves registered
// fetches, and accepts a little-endian byte image while holding the CPU in reset.
module firmware_store #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = DATA_WIDTH'(32'h00000013)
) (
  input  logic             clk,
  input  logic             reset,
  firmware_store_if.slave  bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned BPW    = DATA_WIDTH / 8;
  localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [BIDX_W-1:0]     bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ready_q, hold_q;

  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_waddr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [DATA_WIDTH-1:0] asm_v_c;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Next-state, load assembly and single memory write port
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    wptr_d      = wptr_q;
    bidx_d      = bidx_q;
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = '0;
    mem_wdata_c = '0;
    asm_v_c     = '0;

    case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_ptr_q;
        mem_wdata_c = FILL_WORD;
        clr_ptr_d   = clr_ptr_q + ADDR_WIDTH'(1);
        if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (bus.fetch_valid) begin
          rdata_d  = mem_q[bus.fetch_addr];
          rvalid_d = 1'b1;
        end
        if (bus.ld_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          bidx_d  = '0;
          asm_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        if (bus.ld_start) begin
          wptr_d = '0;
          bidx_d = '0;
          asm_d  = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
        end else begin
          // Byte is consumed first so a same-cycle ld_end sees its effect
          if (bus.ld_byte_valid) begin
            if (cnt_q == CNT_W'(DEPTH)) begin
              ovf_d = 1'b1;
            end else begin
              asm_v_c = asm_q | (DATA_WIDTH'(bus.ld_byte) << {bidx_q, 3'b000});
              if (bidx_q == BIDX_W'(BPW - 1)) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = wptr_q;
                mem_wdata_c = asm_v_c;
                wptr_d      = wptr_q + ADDR_WIDTH'(1);
                cnt_d       = cnt_q + CNT_W'(1);
                bidx_d      = '0;
                asm_d       = '0;
              end else begin
                bidx_d = bidx_q + BIDX_W'(1);
                asm_d  = asm_v_c;
              end
            end
          end
          if (bus.ld_end) begin
            if (bidx_d != '0 && cnt_d != CNT_W'(DEPTH)) begin
              mem_we_c    = 1'b1;
              mem_waddr_c = wptr_d;
              mem_wdata_c = asm_d;
              wptr_d      = wptr_d + ADDR_WIDTH'(1);
              cnt_d       = cnt_d + CNT_W'(1);
            end
            bidx_d  = '0;
            asm_d   = '0;
            done_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
      wptr_q    <= '0;
      bidx_q    <= '0;
      asm_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      ready_q   <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      wptr_q    <= wptr_d;
      bidx_q    <= bidx_d;
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      ready_q   <= (state_d == ST_RUN);
      hold_q    <= (state_d != ST_RUN);
    end
  end

  // Storage has no reset; the CLEAR sweep initialises it
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign bus.fetch_ready = ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.cpu_hold    = hold_q;
  assign bus.ld_done     = done_q;
  assign bus.ld_count    = cnt_q;
  assign bus.ld_overflow = ovf_q;

endmodule
